// File: rtl/teclado_atm.sv
// Keypad front-end for the ATM: debounces raw key levels into single events,
// forwards PIN digits and accumulates decimal amounts.
module teclado_atm #(
  parameter int DEBOUNCE = 4,
  parameter int MAX_DIG  = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  tecla,
  input  logic        tecla_valida,
  input  logic        fase_monto,
  output logic [3:0]  digito,
  output logic        digito_stb,
  output logic [31:0] monto,
  output logic        monto_stb,
  output logic [3:0]  cuenta_dig
);

  localparam logic [3:0] DEB_M1   = 4'(DEBOUNCE - 1);
  localparam logic [3:0] MAXD     = 4'(MAX_DIG);
  localparam logic [3:0] K_BORRAR = 4'hA;
  localparam logic [3:0] K_ACEPT  = 4'hB;

  typedef enum logic [1:0] {IDLE, FILTRO, PRESIONADA, LIBERANDO} est_t;

  est_t        est_q, est_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  cod_q, cod_d;
  logic        evento;

  logic        fase_q;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  ndig_q, ndig_d;
  logic [3:0]  digito_q, digito_d;
  logic        dstb_q, dstb_d;
  logic [31:0] monto_q, monto_d;
  logic        mstb_q, mstb_d;

  logic        cambio;
  logic        es_digito;
  logic [31:0] acc_base;
  logic [3:0]  ndig_base;

  // Debounce filter: counter runs up toward DEBOUNCE on both press and release.
  always_comb begin
    est_d  = est_q;
    cnt_d  = cnt_q;
    cod_d  = cod_q;
    evento = 1'b0;
    case (est_q)
      IDLE: begin
        if (tecla_valida) begin
          est_d = FILTRO;
          cod_d = tecla;
          cnt_d = 4'd1;
        end
      end
      FILTRO: begin
        if (!tecla_valida) begin
          est_d = IDLE;
          cnt_d = 4'd0;
        end else if (tecla != cod_q) begin
          cod_d = tecla;
          cnt_d = 4'd1;
        end else if (cnt_q == DEB_M1) begin
          evento = 1'b1;
          est_d  = PRESIONADA;
          cnt_d  = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      PRESIONADA: begin
        if (!tecla_valida) begin
          est_d = LIBERANDO;
          cnt_d = 4'd1;
        end
      end
      LIBERANDO: begin
        if (tecla_valida) begin
          est_d = PRESIONADA;
          cnt_d = 4'd0;
        end else if (cnt_q == DEB_M1) begin
          est_d = IDLE;
          cnt_d = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        est_d = IDLE;
        cnt_d = 4'd0;
      end
    endcase
  end

  // A phase flip wipes the accumulator first; a same-cycle event then sees the cleared value.
  assign cambio    = fase_monto ^ fase_q;
  assign es_digito = (cod_q <= 4'd9);
  assign acc_base  = cambio ? 32'd0 : acc_q;
  assign ndig_base = cambio ? 4'd0  : ndig_q;

  always_comb begin
    acc_d    = acc_base;
    ndig_d   = ndig_base;
    digito_d = digito_q;
    monto_d  = monto_q;
    dstb_d   = 1'b0;
    mstb_d   = 1'b0;
    if (evento) begin
      if (!fase_monto) begin
        if (es_digito) begin
          digito_d = cod_q;
          dstb_d   = 1'b1;
        end
      end else if (es_digito) begin
        if (ndig_base < MAXD) begin
          acc_d  = acc_base * 32'd10 + {28'd0, cod_q};
          ndig_d = ndig_base + 4'd1;
        end
      end else if (cod_q == K_BORRAR) begin
        acc_d  = 32'd0;
        ndig_d = 4'd0;
      end else if (cod_q == K_ACEPT && ndig_base != 4'd0) begin
        monto_d = acc_base;
        mstb_d  = 1'b1;
        acc_d   = 32'd0;
        ndig_d  = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      est_q    <= IDLE;
      cnt_q    <= 4'd0;
      cod_q    <= 4'd0;
      fase_q   <= 1'b0;
      acc_q    <= 32'd0;
      ndig_q   <= 4'd0;
      digito_q <= 4'd0;
      dstb_q   <= 1'b0;
      monto_q  <= 32'd0;
      mstb_q   <= 1'b0;
    end else begin
      est_q    <= est_d;
      cnt_q    <= cnt_d;
      cod_q    <= cod_d;
      fase_q   <= fase_monto;
      acc_q    <= acc_d;
      ndig_q   <= ndig_d;
      digito_q <= digito_d;
      dstb_q   <= dstb_d;
      monto_q  <= monto_d;
      mstb_q   <= mstb_d;
    end
  end

  assign digito     = digito_q;
  assign digito_stb = dstb_q;
  assign monto      = monto_q;
  assign monto_stb  = mstb_q;
  assign cuenta_dig = ndig_q;

endmodule

// File: tb/tb_teclado_atm.sv
// Bench for teclado_atm: key-press table, hand sequences for bounce/latency/reset,
// and random key traffic checked cycle by cycle against a run-length reference model.
module tb_teclado_atm;
  localparam int DEB  = 4;
  localparam int MAXD = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  tecla;
  logic        tecla_valida;
  logic        fase_monto;
  logic [3:0]  digito;
  logic        digito_stb;
  logic [31:0] monto;
  logic        monto_stb;
  logic [3:0]  cuenta_dig;

  always #5 clk = ~clk;

  teclado_atm #(.DEBOUNCE(DEB), .MAX_DIG(MAXD)) dut (
    .clk(clk), .rst(rst), .tecla(tecla), .tecla_valida(tecla_valida),
    .fase_monto(fase_monto), .digito(digito), .digito_stb(digito_stb),
    .monto(monto), .monto_stb(monto_stb), .cuenta_dig(cuenta_dig)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a press fires when an armed key has been seen DEB edges in a row;
  // it re-arms after DEB consecutive released edges.
  int              run_on, run_off;
  bit              armed;
  logic [3:0]      m_code;
  bit              prev_fase;
  longint unsigned acc;
  int              ndig;
  logic [3:0]      m_dig;
  logic [31:0]     m_monto;
  bit              m_dstb, m_mstb;

  int dstb_seen, mstb_seen, edge_no, stb_edge;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    run_on = 0; run_off = 0; armed = 1; m_code = 4'd0; prev_fase = 0;
    acc = 0; ndig = 0; m_dig = 4'd0; m_monto = 32'd0; m_dstb = 0; m_mstb = 0;
  endtask

  task automatic step();
    bit ev;
    @(posedge clk);
    #1;
    ev = 0;
    if (tecla_valida) begin
      run_off = 0;
      if (run_on > 0 && tecla == m_code) run_on++;
      else begin run_on = 1; m_code = tecla; end
      if (armed && run_on == DEB) begin ev = 1; armed = 0; end
    end else begin
      run_on = 0;
      run_off++;
      if (!armed && run_off >= DEB) armed = 1;
    end
    if (fase_monto != prev_fase) begin acc = 0; ndig = 0; end
    prev_fase = fase_monto;
    m_dstb = 0; m_mstb = 0;
    if (ev) begin
      if (!fase_monto) begin
        if (m_code < 10) begin m_dig = m_code; m_dstb = 1; end
      end else if (m_code < 10) begin
        if (ndig < MAXD) begin acc = acc * 10 + m_code; ndig++; end
      end else if (m_code == 4'hA) begin
        acc = 0; ndig = 0;
      end else if (m_code == 4'hB && ndig > 0) begin
        m_monto = 32'(acc); m_mstb = 1; acc = 0; ndig = 0;
      end
    end
    chk("cycle", {22'd0, digito_stb, digito, monto_stb, monto, cuenta_dig},
                 {22'd0, m_dstb, m_dig, m_mstb, m_monto, 4'(ndig)});
    edge_no++;
    dstb_seen += int'(digito_stb);
    mstb_seen += int'(monto_stb);
    if (digito_stb || monto_stb) stb_edge = edge_no;
  endtask

  task automatic press(input logic [3:0] code, input logic f, input int hold, input int gap);
    tecla = code; fase_monto = f; tecla_valida = 1'b1;
    repeat (hold) step();
    tecla_valida = 1'b0;
    repeat (gap) step();
  endtask

  typedef struct {
    logic        f;
    logic [3:0]  code;
    int          dstb;
    int          mstb;
    logic [3:0]  dig;
    logic [31:0] mon;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic f, input logic [3:0] code, input int ds, input int ms,
                     input logic [3:0] dig, input logic [31:0] mon, input logic [3:0] cnt);
    vec_t v;
    v.f = f; v.code = code; v.dstb = ds; v.mstb = ms; v.dig = dig; v.mon = mon; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  initial begin
    int seq [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
    rst = 1'b0; tecla = 4'd0; tecla_valida = 1'b0; fase_monto = 1'b0;
    dstb_seen = 0; mstb_seen = 0; edge_no = 0; stb_edge = 0;
    model_reset();
    #12;
    chk("reset", {22'd0, digito_stb, digito, monto_stb, monto, cuenta_dig}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // PIN digits, then amount entry with its limits and a phase change
    add(0, 4'd4, 1, 0, 4'd4, 0, 0);
    add(0, 4'd7, 1, 0, 4'd7, 0, 0);
    add(0, 4'd5, 1, 0, 4'd5, 0, 0);
    add(0, 4'd6, 1, 0, 4'd6, 0, 0);
    add(0, 4'hA, 0, 0, 4'd6, 0, 0);
    add(1, 4'd1, 0, 0, 4'd6, 0, 1);
    add(1, 4'd0, 0, 0, 4'd6, 0, 2);
    add(1, 4'd0, 0, 0, 4'd6, 0, 3);
    add(1, 4'd0, 0, 0, 4'd6, 0, 4);
    add(1, 4'd0, 0, 0, 4'd6, 0, 5);
    add(1, 4'hB, 0, 1, 4'd6, 10000, 0);
    add(1, 4'hB, 0, 0, 4'd6, 10000, 0);
    add(1, 4'd2, 0, 0, 4'd6, 10000, 1);
    add(1, 4'd5, 0, 0, 4'd6, 10000, 2);
    add(1, 4'hA, 0, 0, 4'd6, 10000, 0);
    add(1, 4'd1, 0, 0, 4'd6, 10000, 1);
    add(1, 4'd0, 0, 0, 4'd6, 10000, 2);
    add(1, 4'd0, 0, 0, 4'd6, 10000, 3);
    add(1, 4'd0, 0, 0, 4'd6, 10000, 4);
    add(1, 4'hC, 0, 0, 4'd6, 10000, 4);
    add(1, 4'hB, 0, 1, 4'd6, 1000, 0);
    for (int i = 1; i <= 10; i++) add(1, 4'd9, 0, 0, 4'd6, 1000, 4'(i < MAXD ? i : MAXD));
    add(1, 4'hB, 0, 1, 4'd6, 999999999, 0);
    add(1, 4'd1, 0, 0, 4'd6, 999999999, 1);
    add(1, 4'd2, 0, 0, 4'd6, 999999999, 2);
    add(0, 4'hC, 0, 0, 4'd6, 999999999, 0);
    add(1, 4'd7, 0, 0, 4'd6, 999999999, 1);
    add(1, 4'hB, 0, 1, 4'd6, 7, 0);

    foreach (tbl[i]) begin
      dstb_seen = 0; mstb_seen = 0;
      press(tbl[i].code, tbl[i].f, 6, 6);
      chk("tbl_dstb",  64'(dstb_seen),  64'(tbl[i].dstb));
      chk("tbl_mstb",  64'(mstb_seen),  64'(tbl[i].mstb));
      chk("tbl_dig",   64'(digito),     64'(tbl[i].dig));
      chk("tbl_monto", 64'(monto),      64'(tbl[i].mon));
      chk("tbl_cnt",   64'(cuenta_dig), 64'(tbl[i].cnt));
    end

    // Latency: the strobe appears after edge DEB counted from the FILTRO entry edge
    tecla = 4'd5; fase_monto = 1'b0; tecla_valida = 1'b1;
    edge_no = 0; stb_edge = 0;
    repeat (DEB + 2) step();
    tecla_valida = 1'b0;
    repeat (6) step();
    chk("latency", 64'(stb_edge), 64'(DEB));

    // Bouncing press followed by a long hold gives exactly one event
    dstb_seen = 0; mstb_seen = 0; tecla = 4'd3;
    foreach (seq[i]) begin tecla_valida = seq[i][0]; step(); end
    tecla_valida = 1'b1;
    repeat (50) step();
    tecla_valida = 1'b0;
    repeat (6) step();
    chk("bounce_cnt", 64'(dstb_seen), 64'd1);
    chk("bounce_dig", 64'(digito), 64'd3);
    chk("bounce_mstb", 64'(mstb_seen), 64'd0);

    // Random key traffic with bursty levels and occasional phase flips
    for (int s = 0; s < 400; s++) begin
      int len;
      len = int'($urandom_range(1, 10));
      tecla_valida = 1'($urandom_range(0, 1));
      tecla = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) fase_monto = ~fase_monto;
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 9) == 0) tecla = 4'($urandom_range(0, 15));
        step();
      end
    end
    tecla_valida = 1'b0;
    repeat (6) step();

    // Reset while a press is being filtered, then release with the key still down
    press(4'd6, 1'b0, 6, 6);
    tecla = 4'd8; tecla_valida = 1'b1;
    repeat (2) step();
    #2 rst = 1'b0;
    #1;
    chk("rst_async", {22'd0, digito_stb, digito, monto_stb, monto, cuenta_dig}, 64'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    edge_no = 0; stb_edge = 0; dstb_seen = 0;
    repeat (DEB + 3) step();
    tecla_valida = 1'b0;
    repeat (6) step();
    chk("rst_evt_edge", 64'(stb_edge), 64'(DEB));
    chk("rst_evt_cnt", 64'(dstb_seen), 64'd1);
    chk("rst_evt_dig", 64'(digito), 64'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
